// File: rtl/lfsr_gen_if.sv
// Control and observation bundle for lfsr_gen. The period signal and its
// modport entries exist only when LFSR_PERIOD_CNT_EN is defined.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
) ();
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             seed_err;
`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] period;

    modport master (
        output en, load, seed_in,
        input  out, wrap, seed_err, period
    );
    modport slave (
        input  en, load, seed_in,
        output out, wrap, seed_err, period
    );
`else
    modport master (
        output en, load, seed_in,
        input  out, wrap, seed_err
    );
    modport slave (
        input  en, load, seed_in,
        output out, wrap, seed_err
    );
`endif
endinterface

// File: rtl/lfsr_gen.sv
// Galois LFSR with seed load, zero-seed protection and wrap pulse.
// Optional period counter enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1C),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic      clk,
    input  logic      rst,
    lfsr_gen_if.slave bus
);

    // Bit 0 of TAPS is ignored; the msb always feeds back into bit 0.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] s);
        logic msb;
        msb    = s[WIDTH-1];
        f_step = {s[WIDTH-2:0], msb} ^ ({TAPS[WIDTH-1:1], 1'b0} & {WIDTH{msb}});
    endfunction

    function automatic logic [WIDTH-1:0] f_sat_inc(input logic [WIDTH-1:0] v);
        f_sat_inc = (&v) ? v : v + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_start;
    logic             r_wrap;
    logic             r_seed_err;
    logic [WIDTH-1:0] w_next;
    logic             w_hit;
    logic             w_seed_zero;

    assign w_next      = f_step(r_out);
    assign w_hit       = (w_next == r_start);
    assign w_seed_zero = (bus.seed_in == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out      <= SEED;
            r_start    <= SEED;
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
            if (bus.load) begin
                // A zero seed would lock the register up; fall back to SEED.
                if (w_seed_zero) begin
                    r_out      <= SEED;
                    r_start    <= SEED;
                    r_seed_err <= 1'b1;
                end else begin
                    r_out   <= bus.seed_in;
                    r_start <= bus.seed_in;
                end
            end else if (bus.en) begin
                r_out  <= w_next;
                r_wrap <= w_hit;
            end
        end
    end

    assign bus.out      = r_out;
    assign bus.wrap     = r_wrap;
    assign bus.seed_err = r_seed_err;

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_period <= '0;
        end else if (bus.load) begin
            r_count <= '0;
        end else if (bus.en) begin
            if (w_hit) begin
                r_period <= f_sat_inc(r_count);
                r_count  <= '0;
            end else begin
                r_count  <= f_sat_inc(r_count);
            end
        end
    end

    assign bus.period = r_period;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: legacy 4-bit sequence plus a default 8-bit
// instance checked against a polynomial reference through a scoreboard.
module tb_lfsr_gen;

    logic clk;
    logic rst;

    lfsr_gen_if #(.WIDTH(4)) b4 ();
    lfsr_gen_if #(.WIDTH(8)) b8 ();

    lfsr_gen #(.WIDTH(4), .TAPS(4'h2), .SEED(4'd1)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    lfsr_gen u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] out;
        logic       wrap;
        logic       serr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_out;
    logic [7:0] m_start;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Multiply by x modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0];
    endfunction

    task automatic drv8(input logic e, input logic l, input logic [7:0] s);
        exp_t x;
        logic [7:0] n;
        b8.en      = e;
        b8.load    = l;
        b8.seed_in = s;
        x.wrap = 1'b0;
        x.serr = 1'b0;
        if (l) begin
            if (s != 8'h00) begin
                m_out   = s;
                m_start = s;
            end else begin
                m_out   = 8'h01;
                m_start = 8'h01;
                x.serr  = 1'b1;
            end
        end else if (e) begin
            n      = ref_next(m_out);
            x.wrap = (n == m_start);
            m_out  = n;
        end
        x.out = m_out;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("out8", b8.out, x.out);
        check("wrap8", b8.wrap, x.wrap);
        check("seed_err8", b8.seed_err, x.serr);
    endtask

    initial begin
        logic [3:0] tbl4 [15];
        int         seen [256];
        int         distinct;
        int         wraps;
        int         wrap_at;

        tbl4 = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};
        m_out   = 8'h01;
        m_start = 8'h01;

        rst = 1'b0;
        b4.en = 1'b0; b4.load = 1'b0; b4.seed_in = '0;
        b8.en = 1'b0; b8.load = 1'b0; b8.seed_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out4", b4.out, 4'h1);
        check("rst_wrap4", b4.wrap, 1'b0);
        check("rst_out8", b8.out, 8'h01);
        check("rst_wrap8", b8.wrap, 1'b0);
        check("rst_serr8", b8.seed_err, 1'b0);
`ifdef LFSR_PERIOD_CNT_EN
        check("rst_period8", b8.period, 8'h00);
`endif
        rst = 1'b1;

        // Legacy 4-bit sequence.
        b4.en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            check("seq4", b4.out, tbl4[i]);
            check("wrap4", b4.wrap, (i == 14));
        end
        b4.en = 1'b0;

        // Full 255-step run from the reset seed.
        for (int i = 0; i < 256; i++) seen[i] = 0;
        wraps = 0;
        wrap_at = -1;
        for (int i = 1; i <= 255; i++) begin
            drv8(1'b1, 1'b0, 8'h00);
            seen[b8.out]++;
            if (b8.wrap) begin
                wraps++;
                wrap_at = i;
            end
        end
        distinct = 0;
        for (int i = 1; i < 256; i++) if (seen[i] == 1) distinct++;
        check("distinct", distinct, 255);
        check("zero_seen", seen[0], 0);
        check("wrap_count", wraps, 1);
        check("wrap_step", wrap_at, 255);
`ifdef LFSR_PERIOD_CNT_EN
        check("period_run1", b8.period, 8'd255);
`endif

        // Load beats en; then a full period from A5.
        drv8(1'b1, 1'b1, 8'hA5);
        check("load_a5", b8.out, 8'hA5);
        wraps = 0;
        wrap_at = -1;
        for (int i = 1; i <= 255; i++) begin
            drv8(1'b1, 1'b0, 8'h00);
            if (b8.wrap) begin
                wraps++;
                wrap_at = i;
            end
        end
        check("wrap_count_a5", wraps, 1);
        check("wrap_step_a5", wrap_at, 255);
`ifdef LFSR_PERIOD_CNT_EN
        check("period_a5", b8.period, 8'd255);
`endif

        // Zero seed falls back to SEED with a one-cycle error pulse.
        drv8(1'b0, 1'b1, 8'h00);
        drv8(1'b1, 1'b0, 8'h00);
        drv8(1'b1, 1'b0, 8'h00);

        // Alternate en across a wrap step.
        drv8(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 254; i++) drv8(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) drv8((k % 2) == 0, 1'b0, 8'h00);

        // Asynchronous reset between edges, right after an error pulse.
        drv8(1'b1, 1'b1, 8'h00);
`ifdef LFSR_PERIOD_CNT_EN
        check("period_pre_rst", b8.period, 8'd255);
`endif
        #3;
        rst = 1'b0;
        #1;
        check("arst_out8", b8.out, 8'h01);
        check("arst_wrap8", b8.wrap, 1'b0);
        check("arst_serr8", b8.seed_err, 1'b0);
        check("arst_out4", b4.out, 4'h1);
`ifdef LFSR_PERIOD_CNT_EN
        check("arst_period8", b8.period, 8'h00);
`endif
        m_out   = 8'h01;
        m_start = 8'h01;
        sb.delete();
        rst = 1'b1;
        drv8(1'b1, 1'b0, 8'h00);
        drv8(1'b1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
